ex_mem_reg: RTL and testbench

- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures EX results (GPR write, HI/LO write) on each clock edge and presents them to the MEM stage.
- Obeys the central stall vector from the pipeline controller and the exception flush.
- Holds the intermediate state of multi-cycle EX operations (madd/msub accumulate: 64-bit partial result plus step counter) while EX is stalled, and feeds that state back to EX.

---
 rtl/ex_mem_reg_pkg.sv | 31 +++
 rtl/ex_mem_reg.sv | 119 +++++++++++
 tb/tb_ex_mem_reg.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_reg_pkg
//   Shared constants for the pipeline registers of the 5-stage MIPS core.
//   This package holds the bus widths, the NOP/zero values loaded on reset and
//   on bubbles, and the stall-vector bit positions. id_ex, ex_mem and mem_wb
//   all import it, because they share the same bubble/hold template.
// ----------------------------------------------------------------------------
package ex_mem_reg_pkg;

    // Bus widths
    localparam int REG_ADDR_BUS_W = 5;                 // GPR address (RegAddrBus)
    localparam int REG_BUS_W      = 32;                // GPR / HI / LO data (RegBus)
    localparam int DREG_BUS_W     = 2 * REG_BUS_W;     // madd/msub partial (DoubleRegBus)
    localparam int STALL_BUS_W    = 6;                 // PC, IF, ID, EX, MEM, WB

    typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
    typedef logic [REG_BUS_W-1:0]      reg_bus_t;
    typedef logic [DREG_BUS_W-1:0]     double_reg_bus_t;

    // Reset level and NOP / zero values
    localparam logic            RstEnable  = 1'b1;
    localparam reg_addr_bus_t   RegNopAddr = '0;
    localparam reg_bus_t        RegNopData = '0;
    localparam reg_bus_t        ZeroWord   = '0;
    localparam double_reg_bus_t ZeroDWord  = '0;

    // Positions in the stall vector that the EX/MEM register looks at
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

endpackage : ex_mem_reg_pkg

// File: rtl/ex_mem_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_reg
//   EX -> MEM pipeline register of the 5-stage MIPS core.
//   It captures the GPR and HI/LO write results of EX and presents them to MEM
//   one cycle later. It also holds the madd/msub intermediate state (64-bit
//   partial result and 2-bit step counter) while EX is stalled, and feeds that
//   state back to EX.
//
//   Priority on each rising edge (after the asynchronous rst):
//     flush              -> every register takes its reset value
//     EX stalled, MEM on -> bubble to MEM, keep the multi-cycle state from EX
//     EX advancing       -> capture ex_*, clear the multi-cycle state
//     EX and MEM stalled -> hold everything
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall [STALL_W]     per-stage stall vector from the pipeline controller
//   flush               exception flush, synchronous
//   ex_wd/ex_wreg/ex_wdata          GPR write from EX
//   ex_whilo/ex_hi/ex_lo            HI/LO write from EX
//   hilo_i [2*DATA_W], cnt_i [2]    multi-cycle state from EX
//   mem_wd/mem_wreg/mem_wdata       GPR write to MEM (registered)
//   mem_whilo/mem_hi/mem_lo         HI/LO write to MEM (registered)
//   hilo_o, cnt_o                   multi-cycle state back to EX (registered)
// ----------------------------------------------------------------------------
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_BUS_W,
    parameter int DATA_W     = REG_BUS_W,
    parameter int STALL_W    = STALL_BUS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,

    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,

    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    // Reset / bubble values, resized to this instance's widths
    localparam logic [REG_ADDR_W-1:0] NOP_ADDR   = REG_ADDR_W'(RegNopAddr);
    localparam logic [DATA_W-1:0]     NOP_DATA   = DATA_W'(RegNopData);
    localparam logic [DATA_W-1:0]     ZERO_WORD  = DATA_W'(ZeroWord);
    localparam logic [2*DATA_W-1:0]   ZERO_DWORD = (2*DATA_W)'(ZeroDWord);

    logic ex_stalled;
    logic mem_stalled;

    assign ex_stalled  = stall[STALL_EX];
    assign mem_stalled = stall[STALL_MEM];

    // This register ignores the stall bits of the other stages.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_EX-1:0], stall[STALL_W-1:STALL_MEM+1]};

    // NOTE: sequential state uses non-blocking (<=) assignments only. A branch
    // that assigns nothing (the EX+MEM stall case) simply holds the flops.
    // Inside a clocked block this is the intended hold, not a latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            mem_wd    <= NOP_ADDR;
            mem_wreg  <= 1'b0;
            mem_wdata <= NOP_DATA;
            mem_whilo <= 1'b0;
            mem_hi    <= ZERO_WORD;
            mem_lo    <= ZERO_WORD;
            hilo_o    <= ZERO_DWORD;
            cnt_o     <= 2'b00;
        end else if (flush) begin
            // An exception discards everything, including a half-done madd/msub.
            mem_wd    <= NOP_ADDR;
            mem_wreg  <= 1'b0;
            mem_wdata <= NOP_DATA;
            mem_whilo <= 1'b0;
            mem_hi    <= ZERO_WORD;
            mem_lo    <= ZERO_WORD;
            hilo_o    <= ZERO_DWORD;
            cnt_o     <= 2'b00;
        end else if (ex_stalled && !mem_stalled) begin
            // Bubble to MEM. EX is iterating, so keep its partial result.
            mem_wd    <= NOP_ADDR;
            mem_wreg  <= 1'b0;
            mem_wdata <= NOP_DATA;
            mem_whilo <= 1'b0;
            mem_hi    <= ZERO_WORD;
            mem_lo    <= ZERO_WORD;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end else if (!ex_stalled) begin
            // EX advancing: the multi-cycle op (if any) has completed.
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            hilo_o    <= ZERO_DWORD;
            cnt_o     <= 2'b00;
        end
    end

endmodule : ex_mem_reg

// File: tb/tb_ex_mem_reg.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_reg
//   Directed testbench for ex_mem_reg. The bench drives inputs on the falling
//   edge and samples outputs on the falling edge that follows each rising edge.
// ----------------------------------------------------------------------------
module tb_ex_mem_reg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int STALL_W    = 6;
    localparam int OUT_W      = REG_ADDR_W + 1 + DATA_W + 1 + 2*DATA_W + 2*DATA_W + 2;

    logic                  clk;
    logic                  rst;
    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic                  ex_whilo;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic [2*DATA_W-1:0]   hilo_i;
    logic [1:0]            cnt_i;
    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_whilo;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic [2*DATA_W-1:0]   hilo_o;
    logic [1:0]            cnt_o;

    logic [OUT_W-1:0]      all_out;
    assign all_out = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o};

    int errors = 0;
    int checks = 0;

    ex_mem_reg #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W),
        .STALL_W    (STALL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_whilo  (ex_whilo),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_whilo (mem_whilo),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The controller must never run EX while MEM is stalled.
    always @(negedge clk) begin
        if (!rst && !stall[3] && stall[4]) begin
            errors++;
            $display("FAIL illegal_stall: got stall=%b, required stall[3]=1 whenever stall[4]=1", stall);
        end
    end

    // One rising edge, then return on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic [REG_ADDR_W-1:0] wd, input logic wreg,
                            input logic [DATA_W-1:0] wdata, input logic whilo,
                            input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = wdata;
        ex_whilo = whilo;
        ex_hi    = hi;
        ex_lo    = lo;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", all_out);
        end
        rst = 1'b0;
        drive_ex(5'd3, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0011, 32'h0000_0022);
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata} !== {5'd3, 1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL reset_preload: got %h required %h", {mem_wd, mem_wreg, mem_wdata},
                     {5'd3, 1'b1, 32'hCAFE_F00D});
        end
        // Assert rst mid-cycle: the clear must not wait for a rising edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_ex(5'd8, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata} !== {5'd8, 1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL reset_first_capture: got %h required %h", {mem_wd, mem_wreg, mem_wdata},
                     {5'd8, 1'b1, 32'h1234_5678});
        end
    endtask

    task automatic test_hilo();
        stall = 6'b000000;
        drive_ex(5'd0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001);
        hilo_i = 64'hFFFF_0000_FFFF_0000;
        cnt_i  = 2'b11;
        step();
        checks++;
        if ({mem_whilo, mem_hi, mem_lo} !== {1'b1, 32'hDEAD_BEEF, 32'h0000_0001}) begin
            errors++;
            $display("FAIL hilo_pass: got %h required %h", {mem_whilo, mem_hi, mem_lo},
                     {1'b1, 32'hDEAD_BEEF, 32'h0000_0001});
        end
        checks++;
        if ({hilo_o, cnt_o} !== 66'h0) begin
            errors++;
            $display("FAIL hilo_state_clear: got %h required 0", {hilo_o, cnt_o});
        end
    endtask

    task automatic test_bubble();
        stall  = 6'b001111;
        drive_ex(5'd9, 1'b1, 32'h0000_0099, 1'b1, 32'h0000_0055, 32'h0000_0066);
        hilo_i = 64'h0000_0001_FFFF_FFFE;
        cnt_i  = 2'b01;
        step();
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} !== '0) begin
            errors++;
            $display("FAIL bubble_mem: got %h required 0",
                     {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo});
        end
        checks++;
        if ({hilo_o, cnt_o} !== {64'h0000_0001_FFFF_FFFE, 2'b01}) begin
            errors++;
            $display("FAIL bubble_state: got %h required %h", {hilo_o, cnt_o},
                     {64'h0000_0001_FFFF_FFFE, 2'b01});
        end
        stall  = 6'b000000;
        drive_ex(5'd10, 1'b1, 32'h0000_0042, 1'b0, 32'h0, 32'h0);
        hilo_i = 64'h0000_0002_0000_0003;
        cnt_i  = 2'b10;
        step();
        checks++;
        if ({hilo_o, cnt_o} !== 66'h0) begin
            errors++;
            $display("FAIL release_state: got %h required 0", {hilo_o, cnt_o});
        end
        checks++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo} !== {5'd10, 1'b1, 32'h0000_0042, 1'b0}) begin
            errors++;
            $display("FAIL release_mem: got %h required %h", {mem_wd, mem_wreg, mem_wdata, mem_whilo},
                     {5'd10, 1'b1, 32'h0000_0042, 1'b0});
        end
    endtask

    task automatic test_hold();
        logic [OUT_W-1:0] exp_out;
        stall  = 6'b000000;
        drive_ex(5'd17, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h0000_1111, 32'h0000_2222);
        step();
        exp_out = {5'd17, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h0000_1111, 32'h0000_2222, 64'h0, 2'b00};
        stall  = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            drive_ex(~ex_wd, ~ex_wreg, ~ex_wdata, ~ex_whilo, ~ex_hi, ~ex_lo);
            hilo_i = ~hilo_i;
            cnt_i  = ~cnt_i;
            step();
            checks++;
            if (all_out !== exp_out) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h required %h", i, all_out, exp_out);
            end
        end
        // Hold must also keep a pending multi-cycle state.
        stall  = 6'b001111;
        hilo_i = 64'h0123_4567_89AB_CDEF;
        cnt_i  = 2'b11;
        step();
        stall  = 6'b011111;
        for (int i = 0; i < 2; i++) begin
            hilo_i = 64'hFEDC_BA98_7654_3210;
            cnt_i  = 2'b00;
            step();
            checks++;
            if ({hilo_o, cnt_o} !== {64'h0123_4567_89AB_CDEF, 2'b11}) begin
                errors++;
                $display("FAIL hold_state%0d: got %h required %h", i, {hilo_o, cnt_o},
                         {64'h0123_4567_89AB_CDEF, 2'b11});
            end
        end
    endtask

    task automatic test_flush();
        // Entered with hilo_o/cnt_o nonzero from test_hold.
        stall = 6'b011111;
        flush = 1'b1;
        drive_ex(5'd21, 1'b1, 32'h7777_7777, 1'b1, 32'h1, 32'h2);
        step();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL flush_over_hold: got %h required 0", all_out);
        end
        stall  = 6'b001111;
        hilo_i = 64'h1111_2222_3333_4444;
        cnt_i  = 2'b10;
        step();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL flush_over_bubble: got %h required 0", all_out);
        end
        stall = 6'b000000;
        step();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL flush_over_capture: got %h required 0", all_out);
        end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [REG_ADDR_W-1:0] wd_tab [8];
        logic [DATA_W-1:0]     wdata_tab [8];
        wd_tab    = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
        wdata_tab = '{32'h0000_0001, 32'h0000_0020, 32'h0000_0300, 32'h0000_4000,
                      32'h0005_0000, 32'h0060_0000, 32'h0700_0000, 32'h8000_0000};
        stall = 6'b000000;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_ex(wd_tab[i], 1'b1, wdata_tab[i], 1'b0, 32'h0, 32'h0);
            step();
            checks++;
            if ({mem_wd, mem_wreg, mem_wdata} !== {wd_tab[i], 1'b1, wdata_tab[i]}) begin
                errors++;
                $display("FAIL stream%0d: got %h required %h", i, {mem_wd, mem_wreg, mem_wdata},
                         {wd_tab[i], 1'b1, wdata_tab[i]});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        stall  = '0;
        hilo_i = '0;
        cnt_i  = '0;
        drive_ex('0, 1'b0, '0, 1'b0, '0, '0);

        test_reset();
        test_hilo();
        test_bubble();
        test_hold();
        test_flush();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex_mem_reg
